alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, parametrised successor to the datapath ALU.
- Keeps the 6-bit ALU control encoding, and adds a post-ALU shifter, carry and overflow flags, and an iterative unsigned multiply mode.
- Uses a start/valid/busy handshake, so the control store can issue an operation and wait for its result.
- Sits between the A/B bus latches and the C bus; the registered outputs feed the C-bus driver and the N/Z flip-flops.

Parameters:
- NBITS, 32: datapath width; must be ≥ 9.
- SHIFT_L, 8: left-shift distance for shift_control = 2'b10; must be < NBITS.
- MUL_EN, 1: 1 instantiates the multiply path; 0 makes mul treated as 0.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: issue the operation; sampled only while busy = 0.
- mul, input, 1: with start, selects multiply instead of alu_control.
- a, input, NBITS: A operand.
- b_bus, input, NBITS: B operand.
- alu_control, input, 6: function code, same encoding as the datapath ALU.
- shift_control, input, 2: 00 none, 01 SRA1, 10 SLL by SHIFT_L, 11 none.
- c, output, NBITS: registered result, after the shifter.
- n, output, 1: registered sign of the pre-shift result.
- z, output, 1: registered zero flag of the pre-shift result.
- cout, output, 1: registered carry/borrow-out.
- ovf, output, 1: registered signed overflow (ALU ops) or product overflow (mul).
- busy, output, 1: multiply in progress.
- valid, output, 1: one-cycle pulse when c and the flags update.

Behaviour:
- Reset (asynchronous, active-high):
  - c = 0, n = 0, z = 1, cout = 0, ovf = 0, busy = 0, valid = 0, state = IDLE, counter = 0.
- FSM states: IDLE, MUL.
- ALU op (IDLE, start = 1, mul = 0):
  - Operands, alu_control and shift_control are sampled at the edge.
  - Results and flags are registered on that same edge; valid = 1 in the following cycle, so latency is 1.
  - A new op can be issued every cycle.
- Function table (hex code: result):
  - 18: A
  - 14: B
  - 1A: ~A
  - 2C: ~B
  - 3C: A+B
  - 3D: A+B+1
  - 39: A+1
  - 35: B+1
  - 3F: B−A
  - 37: B−1
  - 3B: −A
  - 0C: A&B
  - 1C: A|B
  - 10: 0
  - 11: 1
  - 12: all-ones
  - Any other code: A, with cout = 0 and ovf = 0.
- Arithmetic rules:
  - Computed at NBITS+1 bits; cout = bit NBITS.
  - Subtraction is B + ~A + 1, so cout = 1 means no borrow.
  - Logic, pass and constant ops force cout = 0 and ovf = 0.
  - ovf uses the standard two's-complement rule on the effective adder operands.
- Flags and shifter:
  - n = r[NBITS−1] and z = (r == 0), where r is the ALU result before the shifter.
  - c = shift(r). SRA1 replicates the MSB; SLL zero-fills.
- Multiply (IDLE, start = 1, mul = 1, MUL_EN = 1):
  - The operands are latched and the FSM goes to MUL with busy = 1 on the next cycle.
  - Shift-add, one bit per cycle, NBITS iterations; the 2·NBITS product is built internally.
  - On the final iteration edge: c = product[NBITS−1:0] (shift_control ignored), n = c MSB, z = (c == 0), ovf = |product[2NBITS−1:NBITS], cout = 0.
  - Also on that edge busy falls and valid pulses in the next cycle; FSM returns to IDLE.
  - Latency: start edge to valid = NBITS+1 cycles.
- Boundaries:
  - start while busy: ignored, no queuing.
  - start = 0: outputs hold, valid = 0.
  - Reset mid-multiply: immediate abort to the reset values; no valid pulse.
  - Operand changes during MUL: no effect, since operands are latched.
  - MUL_EN = 0: mul is ignored and the ALU op executes.
  - valid is never high while busy is high.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum with the 16 codes.
  - shift_op_e enum: SH_NONE, SH_SRA1, SH_SLL.
  - ALU_CONTROL = 6.
  - alu_state_e enum: IDLE, MUL.
- One sub-module, alu_shift_mul: the iterative multiplier (operand registers, counter, product register, done strobe).
- The ALU, shifter and output registers live in alu_seq.

Test Plan:
1. NBITS = 32, reset asserted mid-cycle → all outputs take their reset values immediately (z = 1); after release, valid stays 0 until a start.
2. a = 0x7FFFFFFF, b = 1, op 3C, no shift, start → next cycle valid = 1, c = 0x80000000, n = 1, z = 0, cout = 0, ovf = 1.
3. a = 5, b = 5, op 3F → c = 0, z = 1, cout = 1, ovf = 0. Then a = 0x80000000, op 18, shift 01 → c = 0xC0000000, n = 1.
4. a = 0x00000012, op 18, shift 10 → c = 0x00001200. Then op 0x05 (illegal) with a = 0xABCD → c = 0xABCD, cout = 0, ovf = 0.
5. mul, a = 0x10000, b = 0x10003 → busy high for 32 cycles, valid at cycle 33, c = 0x00030000, ovf = 1. Also drive start pulses during busy → ignored.
6. mul, a = 7, b = 6, reset at cycle 10 → abort with no valid. Reissue → c = 42, ovf = 0, z = 0, valid once.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: function codes,
// shifter selects, FSM states.
package alu_pkg;

  localparam int ALU_CONTROL = 6;

  typedef enum logic [ALU_CONTROL-1:0] {
    OP_ZERO = 6'h10,
    OP_ONE  = 6'h11,
    OP_ONES = 6'h12,
    OP_B    = 6'h14,
    OP_A    = 6'h18,
    OP_NOTA = 6'h1A,
    OP_AND  = 6'h0C,
    OP_OR   = 6'h1C,
    OP_NOTB = 6'h2C,
    OP_INCB = 6'h35,
    OP_DECB = 6'h37,
    OP_INCA = 6'h39,
    OP_NEGA = 6'h3B,
    OP_ADD  = 6'h3C,
    OP_ADDC = 6'h3D,
    OP_SUB  = 6'h3F
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_SRA1 = 2'b01,
    SH_SLL  = 2'b10
  } shift_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_shift_mul.sv
// Iterative shift-add unsigned multiplier, one bit per cycle.
// Ports: clk, reset, start, a, b -> busy, done, product.
// done/product are combinational: they describe the final
// iteration edge, so the parent captures product on it.
module alu_shift_mul
  import alu_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NBITS-1:0]   a,
  input  logic [NBITS-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*NBITS-1:0] product
);

  localparam int CW = $clog2(NBITS);

  alu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NBITS-1:0]   mcand_q, mcand_d;
  logic [2*NBITS-1:0] prod_q, prod_d;
  logic [NBITS:0]     psum;
  logic               last;

  // Low half of prod_q starts as the multiplier and is
  // consumed LSB-first while the partial sum fills the top.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    done    = 1'b0;
    last    = (cnt_q == CW'(NBITS-1));
    psum    = {1'b0, prod_q[2*NBITS-1:NBITS]}
            + {1'b0, (prod_q[0] ? mcand_q
                                : {NBITS{1'b0}})};
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          prod_d  = {{NBITS{1'b0}}, b};
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        prod_d = {psum, prod_q[NBITS-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q == MUL);
  assign product = prod_d;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with post-shifter, carry/overflow flags and
// iterative multiply. Ports: clk, reset, start, mul, a,
// b_bus, alu_control, shift_control -> c, n, z, cout, ovf,
// busy, valid (one-cycle pulse when c and flags update).
module alu_seq
  import alu_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int SHIFT_L = 8,
  parameter int MUL_EN  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mul,
  input  logic [NBITS-1:0]       a,
  input  logic [NBITS-1:0]       b_bus,
  input  logic [ALU_CONTROL-1:0] alu_control,
  input  logic [1:0]             shift_control,
  output logic [NBITS-1:0]       c,
  output logic                   n,
  output logic                   z,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy,
  output logic                   valid
);

  logic               mul_sel;
  logic               mul_busy;
  logic               mul_done;
  logic [2*NBITS-1:0] mul_prod;

  assign mul_sel = mul && (MUL_EN != 0);

  if (MUL_EN != 0) begin : g_mul
    alu_shift_mul #(.NBITS(NBITS)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (start && mul_sel),
      .a       (a),
      .b       (b_bus),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_prod)
    );
  end else begin : g_no_mul
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  logic [NBITS-1:0] x, y, r, sh_r;
  logic [NBITS:0]   sum;
  logic             cin, arith;
  logic             a_cout, a_ovf;

  // Every arithmetic op is one adder pass x + y + cin;
  // subtraction feeds ~A with cin = 1.
  always_comb begin
    x     = '0;
    y     = '0;
    cin   = 1'b0;
    arith = 1'b0;
    r     = a;
    case (alu_control)
      OP_A:    r = a;
      OP_B:    r = b_bus;
      OP_NOTA: r = ~a;
      OP_NOTB: r = ~b_bus;
      OP_AND:  r = a & b_bus;
      OP_OR:   r = a | b_bus;
      OP_ZERO: r = '0;
      OP_ONE:  r = NBITS'(1);
      OP_ONES: r = '1;
      OP_ADD: begin
        arith = 1'b1; x = a; y = b_bus;
      end
      OP_ADDC: begin
        arith = 1'b1; x = a; y = b_bus; cin = 1'b1;
      end
      OP_INCA: begin
        arith = 1'b1; x = a; cin = 1'b1;
      end
      OP_INCB: begin
        arith = 1'b1; x = b_bus; cin = 1'b1;
      end
      OP_SUB: begin
        arith = 1'b1; x = b_bus; y = ~a; cin = 1'b1;
      end
      OP_DECB: begin
        arith = 1'b1; x = b_bus; y = '1;
      end
      OP_NEGA: begin
        arith = 1'b1; y = ~a; cin = 1'b1;
      end
      default: r = a;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{NBITS{1'b0}}, cin};
    if (arith) r = sum[NBITS-1:0];
    a_cout = arith & sum[NBITS];
    a_ovf  = arith & (x[NBITS-1] ~^ y[NBITS-1])
                   & (sum[NBITS-1] ^ x[NBITS-1]);
  end

  always_comb begin
    case (shift_control)
      SH_SRA1: sh_r = {r[NBITS-1], r[NBITS-1:1]};
      SH_SLL:  sh_r = r << SHIFT_L;
      default: sh_r = r;
    endcase
  end

  logic [NBITS-1:0] c_q, c_d;
  logic n_q, n_d, z_q, z_d;
  logic cout_q, cout_d, ovf_q, ovf_d;
  logic valid_q, valid_d;

  // While busy, start is dropped; the done edge loads the
  // product and nothing else can compete with it.
  always_comb begin
    c_d     = c_q;
    n_d     = n_q;
    z_d     = z_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (mul_done) begin
      c_d     = mul_prod[NBITS-1:0];
      n_d     = mul_prod[NBITS-1];
      z_d     = ~|mul_prod[NBITS-1:0];
      cout_d  = 1'b0;
      ovf_d   = |mul_prod[2*NBITS-1:NBITS];
      valid_d = 1'b1;
    end else if (start && !mul_busy && !mul_sel) begin
      c_d     = sh_r;
      n_d     = r[NBITS-1];
      z_d     = ~|r;
      cout_d  = a_cout;
      ovf_d   = a_ovf;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q     <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      c_q     <= c_d;
      n_q     <= n_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign c     = c_q;
  assign n     = n_q;
  assign z     = z_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
  assign busy  = mul_busy;
  assign valid = valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq (NBITS = 32)
// against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mul;
  logic [31:0] a;
  logic [31:0] b_bus;
  logic [5:0]  alu_control;
  logic [1:0]  shift_control;
  logic [31:0] c;
  logic        n, z, cout, ovf, busy, valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] c;
    logic        n;
    logic        z;
    logic        co;
    logic        ov;
  } res_t;

  res_t last;

  always #5 clk = ~clk;

  alu_seq #(.NBITS(32), .SHIFT_L(8), .MUL_EN(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mul           (mul),
    .a             (a),
    .b_bus         (b_bus),
    .alu_control   (alu_control),
    .shift_control (shift_control),
    .c             (c),
    .n             (n),
    .z             (z),
    .cout          (cout),
    .ovf           (ovf),
    .busy          (busy),
    .valid         (valid)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic res_t model_alu(
    input logic [31:0] ia, ib,
    input logic [5:0] op, input logic [1:0] sh);
    res_t        e;
    logic [31:0] r;
    longint      ua, ub, sa, sb, s;
    logic        ar, co;
    ua = longint'({32'd0, ia});
    ub = longint'({32'd0, ib});
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    ar = 1'b1;
    co = 1'b0;
    s  = 0;
    case (op)
      6'h18: begin r = ia;        ar = 1'b0; end
      6'h14: begin r = ib;        ar = 1'b0; end
      6'h1A: begin r = ~ia;       ar = 1'b0; end
      6'h2C: begin r = ~ib;       ar = 1'b0; end
      6'h0C: begin r = ia & ib;   ar = 1'b0; end
      6'h1C: begin r = ia | ib;   ar = 1'b0; end
      6'h10: begin r = 32'd0;     ar = 1'b0; end
      6'h11: begin r = 32'd1;     ar = 1'b0; end
      6'h12: begin r = '1;        ar = 1'b0; end
      6'h3C: begin
        r = ia + ib; s = sa + sb;
        co = (ua + ub) >= 64'h1_0000_0000;
      end
      6'h3D: begin
        r = ia + ib + 32'd1; s = sa + sb + 1;
        co = (ua + ub + 1) >= 64'h1_0000_0000;
      end
      6'h39: begin
        r = ia + 32'd1; s = sa + 1;
        co = (ua + 1) >= 64'h1_0000_0000;
      end
      6'h35: begin
        r = ib + 32'd1; s = sb + 1;
        co = (ub + 1) >= 64'h1_0000_0000;
      end
      6'h3F: begin
        r = ib - ia; s = sb - sa; co = (ub >= ua);
      end
      6'h37: begin
        r = ib - 32'd1; s = sb - 1; co = (ub >= 1);
      end
      6'h3B: begin
        r = 32'd0 - ia; s = -sa; co = (ua == 0);
      end
      default: begin r = ia; ar = 1'b0; end
    endcase
    e.co = ar & co;
    e.ov = ar && (s > 64'sd2147483647 ||
                  s < -64'sd2147483648);
    e.n  = r[31];
    e.z  = (r == 32'd0);
    case (sh)
      2'b01:   e.c = 32'($signed(r) >>> 1);
      2'b10:   e.c = r << 8;
      default: e.c = r;
    endcase
    return e;
  endfunction

  function automatic res_t model_mul(
    input logic [31:0] ia, ib);
    res_t        e;
    logic [63:0] p;
    p    = {32'd0, ia} * {32'd0, ib};
    e.c  = p[31:0];
    e.n  = p[31];
    e.z  = (p[31:0] == 32'd0);
    e.co = 1'b0;
    e.ov = (p[63:32] != 32'd0);
    return e;
  endfunction

  task automatic alu_op(input logic [31:0] ia, ib,
                        input logic [5:0] op,
                        input logic [1:0] sh);
    res_t e;
    @(negedge clk);
    a = ia; b_bus = ib; alu_control = op;
    shift_control = sh; mul = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    e = model_alu(ia, ib, op, sh);
    check("alu_valid", valid, 1);
    check("alu_busy", busy, 0);
    check("alu_c", c, e.c);
    check("alu_n", n, e.n);
    check("alu_z", z, e.z);
    check("alu_cout", cout, e.co);
    check("alu_ovf", ovf, e.ov);
    last = e;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b_bus = $urandom;
      mul = 1'($urandom);
      alu_control = 6'($urandom);
      @(posedge clk);
      #1;
      check("idle_valid", valid, 0);
      check("idle_c_hold", c, last.c);
    end
  endtask

  task automatic run_mul(input logic [31:0] ma, mb,
                         input bit noise);
    res_t e;
    int   cyc, bcnt, lat;
    bit   got;
    e = model_mul(ma, mb);
    @(negedge clk);
    a = ma; b_bus = mb; mul = 1'b1; start = 1'b1;
    alu_control = 6'($urandom);
    shift_control = 2'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1; bcnt = 0; lat = 0; got = 1'b0;
    while (cyc <= 40 && !got) begin
      if (valid) begin
        got = 1'b1;
        lat = cyc;
      end else begin
        if (busy) begin
          bcnt++;
          if (noise) begin
            start = 1'($urandom);
            mul = 1'($urandom);
            a = $urandom; b_bus = $urandom;
            alu_control = 6'($urandom);
          end
        end
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    start = 1'b0;
    check("mul_valid_seen", got, 1);
    check("mul_latency", lat, 33);
    check("mul_busy_cycles", bcnt, 32);
    check("mul_busy_at_valid", busy, 0);
    check("mul_c", c, e.c);
    check("mul_n", n, e.n);
    check("mul_z", z, e.z);
    check("mul_cout", cout, e.co);
    check("mul_ovf", ovf, e.ov);
    last = e;
    @(posedge clk);
    #1;
    check("mul_valid_pulse", valid, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_c"}, c, 0);
    check({tag, "_n"}, n, 0);
    check({tag, "_z"}, z, 1);
    check({tag, "_cout"}, cout, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, valid, 0);
  endtask

  logic [5:0] codes [18] = '{
    6'h18, 6'h14, 6'h1A, 6'h2C, 6'h3C, 6'h3D,
    6'h39, 6'h35, 6'h3F, 6'h37, 6'h3B, 6'h0C,
    6'h1C, 6'h10, 6'h11, 6'h12, 6'h05, 6'h3E
  };
  logic [31:0] edges [5] = '{
    32'h0, 32'h7FFF_FFFF, 32'h8000_0000,
    32'hFFFF_FFFF, 32'h1
  };

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 2) == 0)
      return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; mul = 1'b0;
    a = '0; b_bus = '0;
    alu_control = 6'h18; shift_control = 2'b00;
    last = '{32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    alu_op(32'h7FFF_FFFF, 32'd1, 6'h3C, 2'b00);
    check("t2_c", c, 32'h8000_0000);
    check("t2_ovf", ovf, 1);
    alu_op(32'd5, 32'd5, 6'h3F, 2'b00);
    check("t3_z", z, 1);
    check("t3_cout", cout, 1);
    alu_op(32'h8000_0000, 32'd0, 6'h18, 2'b01);
    check("t3_sra", c, 32'hC000_0000);
    alu_op(32'h12, 32'd0, 6'h18, 2'b10);
    check("t4_sll", c, 32'h0000_1200);
    alu_op(32'hABCD, 32'h1234, 6'h05, 2'b00);
    check("t4_illegal", c, 32'hABCD);
    idle(2);

    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    last = '{32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    idle(2);

    run_mul(32'h1_0000, 32'h1_0003, 1'b1);
    check("t5_c", c, 32'h0003_0000);
    idle(1);

    @(negedge clk);
    a = 32'd7; b_bus = 32'd6; mul = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    reset = 1'b0;
    begin
      int vcnt = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (valid) vcnt++;
      end
      check("abort_no_valid", vcnt, 0);
    end
    run_mul(32'd7, 32'd6, 1'b0);
    check("t6_c", c, 32'd42);

    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 5) == 0) op = 6'($urandom);
      else op = codes[$urandom_range(0, 17)];
      alu_op(pick(), pick(), op, 2'($urandom));
      if ($urandom_range(0, 19) == 0) idle(1);
    end

    for (int i = 0; i < 6; i++)
      run_mul(pick(), pick(), 1'b1);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_mul(32'd0, 32'h1234_5678, 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
